// File: rtl/regfile_dump_streamer_pkg.sv
// Shared definitions for the register-file dump streamer.
// Contents: dump sequencing states, output tag constants and a helper that
// turns a register index into the tag carried alongside that register's beat.
package regfile_dump_streamer_pkg;

   // Width of the register-file read address and of the output tag field.
   localparam int RADDR_W = 5;
   localparam int TAG_W   = 6;

   // Tags that frame a dump: the header carries the PC, the trailer the XOR checksum.
   localparam logic [TAG_W-1:0] TAG_HDR = 6'h00;
   localparam logic [TAG_W-1:0] TAG_TRL = 6'h3F;

   // Dump sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_REGS,
      ST_TRL,
      ST_FIN
   } dumpState_t;

   // Register beats are tagged with their own index; the top tag bit stays clear
   // so a register tag can never collide with the trailer tag.
   function automatic logic [TAG_W-1:0] regTag(input logic [RADDR_W-1:0] idx);
      return {1'b0, idx};
   endfunction

endpackage

// File: rtl/regfile_dump_streamer_out_buffer.sv
// dump_out_buffer: single-entry valid/ready output register for the dump stream.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   i_load         - request to place a new word into the register
//   i_data, i_tag  - word and tag to place
//   i_ready        - downstream consumer accepts the held word this cycle
//   o_valid        - a word is held and offered downstream
//   o_data, o_tag  - the held word and tag
//   o_canLoad      - the register is free (empty, or its word leaves this cycle)
module dump_out_buffer #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [XLEN-1:0]  i_data,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [XLEN-1:0]  o_data,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_canLoad
);

   logic             r_valid;
   logic [XLEN-1:0]  r_data;
   logic [TAG_W-1:0] r_tag;
   logic             w_canLoad;

   // A new word may enter only when the current one is gone or departing, so a
   // stalled word is never overwritten.
   assign w_canLoad = !r_valid || i_ready;

   // Holding register: loads when free, otherwise keeps data/tag frozen until
   // the consumer takes the word; valid only drops on acceptance without a reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tag   <= '0;
      end else if (i_load && w_canLoad) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_tag   <= i_tag;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_tag     = r_tag;
   assign o_canLoad = w_canLoad;

endmodule

// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer: on a dump request, streams a snapshot of the register
// file as header (PC), registers FIRST_REG..NUM_REGS-1, then trailer (XOR checksum).
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   i_dump_req          - single-cycle pulse starting a dump (ignored while busy)
//   i_pc_in             - PC captured into the header when a dump starts
//   o_rf_raddr          - spare register-file read address
//   i_rf_rdata          - combinational read data for o_rf_raddr
//   o_out_valid/o_out_ready handshake with o_out_data/o_out_tag payload
//   o_busy              - dump in progress
//   o_done              - one-cycle pulse after the trailer is accepted
module regfile_dump_streamer
   import regfile_dump_streamer_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_REGS  = 32,
   parameter int FIRST_REG = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_dump_req,
   input  logic [XLEN-1:0]    i_pc_in,
   output logic [RADDR_W-1:0] o_rf_raddr,
   input  logic [XLEN-1:0]    i_rf_rdata,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [XLEN-1:0]    o_out_data,
   output logic [TAG_W-1:0]   o_out_tag,
   output logic               o_busy,
   output logic               o_done
);

   localparam logic [RADDR_W-1:0] FIRST_IDX = RADDR_W'(FIRST_REG);
   localparam logic [RADDR_W-1:0] LAST_IDX  = RADDR_W'(NUM_REGS - 1);

   dumpState_t         r_state;
   dumpState_t         w_nextState;
   logic [RADDR_W-1:0] r_idx;
   logic [RADDR_W-1:0] w_nextIdx;
   logic [XLEN-1:0]    r_checksum;
   logic [XLEN-1:0]    w_nextChecksum;

   logic               w_load;
   logic [XLEN-1:0]    w_loadData;
   logic [TAG_W-1:0]   w_loadTag;
   logic               w_canLoad;
   logic               w_outValid;
   logic [XLEN-1:0]    w_outData;
   logic [TAG_W-1:0]   w_outTag;

   dump_out_buffer #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W)
   ) u_outBuffer (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_data    (w_loadData),
      .i_tag     (w_loadTag),
      .i_ready   (i_out_ready),
      .o_valid   (w_outValid),
      .o_data    (w_outData),
      .o_tag     (w_outTag),
      .o_canLoad (w_canLoad)
   );

   // State, register pointer and running checksum advance together; reset
   // abandons any partial dump without producing a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_checksum <= '0;
      end else begin
         r_state    <= w_nextState;
         r_idx      <= w_nextIdx;
         r_checksum <= w_nextChecksum;
      end
   end

   // Sequencing. The header is loaded straight from i_pc_in in the request
   // cycle so it is on the bus one cycle later. HDR and REGS share the register
   // load path: while the header sits on the bus the read port already points at
   // the first register, so register beats follow without a bubble. TRL first
   // loads the checksum, then waits for that trailer beat to be accepted.
   always_comb begin
      w_nextState    = r_state;
      w_nextIdx      = r_idx;
      w_nextChecksum = r_checksum;
      w_load         = 1'b0;
      w_loadData     = '0;
      w_loadTag      = TAG_HDR;
      o_rf_raddr     = '0;
      o_busy         = 1'b0;
      o_done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_dump_req) begin
               w_load         = 1'b1;
               w_loadData     = i_pc_in;
               w_loadTag      = TAG_HDR;
               w_nextChecksum = i_pc_in;
               w_nextIdx      = FIRST_IDX;
               w_nextState    = ST_HDR;
            end
         end
         ST_HDR, ST_REGS: begin
            o_busy     = 1'b1;
            o_rf_raddr = r_idx;
            if (w_canLoad) begin
               w_load         = 1'b1;
               w_loadData     = i_rf_rdata;
               w_loadTag      = regTag(r_idx);
               w_nextChecksum = r_checksum ^ i_rf_rdata;
               w_nextIdx      = r_idx + 1'b1;
               w_nextState    = (r_idx == LAST_IDX) ? ST_TRL : ST_REGS;
            end
         end
         ST_TRL: begin
            o_busy = 1'b1;
            if (w_outValid && (w_outTag == TAG_TRL)) begin
               if (i_out_ready) begin
                  w_nextState = ST_FIN;
               end
            end else if (w_canLoad) begin
               w_load     = 1'b1;
               w_loadData = r_checksum;
               w_loadTag  = TAG_TRL;
            end
         end
         ST_FIN: begin
            o_done      = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign o_out_valid = w_outValid;
   assign o_out_data  = w_outData;
   assign o_out_tag   = w_outTag;

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Self-checking bench for regfile_dump_streamer: table of dump scenarios plus
// hand-written corner sequences and randomized backpressure/contents.
module tb_regfile_dump_streamer;

   logic        clk;
   logic        reset;
   logic        dumpReq;
   logic [31:0] pcIn;
   logic [4:0]  rfRaddr;
   logic [31:0] rfRdata;
   logic        outValid;
   logic        outReady;
   logic [31:0] outData;
   logic [5:0]  outTag;
   logic        busy;
   logic        done;

   logic [31:0] rf [32];

   int errors;
   int checks;
   int doneTotal;
   int doneCycle;
   int firstBeatCycle;
   int lastBeatCycle;

   logic [5:0]  gotTag[$];
   logic [31:0] gotData[$];
   logic [5:0]  expTag[$];
   logic [31:0] expData[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rfBase;
      int          mode;
      int          reqA;
      int          reqB;
      int          expDone;
   } vec_t;

   vec_t vecs[4];

   regfile_dump_streamer dut (
      .clk         (clk),
      .reset       (reset),
      .i_dump_req  (dumpReq),
      .i_pc_in     (pcIn),
      .o_rf_raddr  (rfRaddr),
      .i_rf_rdata  (rfRdata),
      .o_out_valid (outValid),
      .i_out_ready (outReady),
      .o_out_data  (outData),
      .o_out_tag   (outTag),
      .o_busy      (busy),
      .o_done      (done)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side register file with a combinational read port.
   assign rfRdata = rf[rfRaddr];

   // Global done-pulse counter, used to prove exactly one pulse per dump.
   always @(negedge clk) begin
      if (done) doneTotal++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fillRf(input logic [31:0] base, input bit rnd);
      for (int i = 0; i < 32; i++) rf[i] = rnd ? $urandom : base + 32'(i);
   endtask

   // Reference model: header PC, registers 1..31 as held in the bench regfile,
   // trailer = XOR of every preceding word.
   task automatic buildExpected(input logic [31:0] pc);
      logic [31:0] x;
      expTag.delete();
      expData.delete();
      x = pc;
      expTag.push_back(6'h00);
      expData.push_back(pc);
      for (int r = 1; r < 32; r++) begin
         expTag.push_back(6'(r));
         expData.push_back(rf[r]);
         x = x ^ rf[r];
      end
      expTag.push_back(6'h3F);
      expData.push_back(x);
   endtask

   // Runs one dump. mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random.
   // reqA/reqB: accepted-beat counts at which a spurious dump_req is pulsed.
   // resetAt: accepted-beat count at which reset is pulsed (dump abandoned).
   // writeReg/writeVal: register written in the cycle before it is loaded.
   task automatic applyStimulus(input logic [31:0] pc, input int mode, input int reqA,
                                input int reqB, input int resetAt, input int writeReg,
                                input logic [31:0] writeVal);
      int          cycle;
      int          accepted;
      bit          pulsedA;
      bit          pulsedB;
      bit          wrote;
      bit          prevStall;
      bit          finished;
      logic [31:0] prevData;
      logic [5:0]  prevTag;
      gotTag.delete();
      gotData.delete();
      doneCycle      = -1;
      firstBeatCycle = -1;
      lastBeatCycle  = -1;
      pulsedA = 0; pulsedB = 0; wrote = 0; prevStall = 0; finished = 0;
      prevData = '0; prevTag = '0;
      outReady = 1'b1;
      dumpReq  = 1'b1;
      pcIn     = pc;
      tick();
      dumpReq  = 1'b0;
      pcIn     = $urandom;
      cycle    = 1;
      accepted = 0;
      while (!finished && cycle < 400) begin
         case (mode)
            0:       outReady = 1'b1;
            1:       outReady = (((cycle - 1) % 4) == 0) || (((cycle - 1) % 4) == 3);
            default: outReady = 1'($urandom_range(0, 1));
         endcase
         if (reqA >= 0 && accepted == reqA && !pulsedA) begin
            dumpReq = 1'b1; pulsedA = 1;
         end else if (reqB >= 0 && accepted == reqB && !pulsedB) begin
            dumpReq = 1'b1; pulsedB = 1;
         end else begin
            dumpReq = 1'b0;
         end
         if (writeReg > 0 && !wrote && accepted == writeReg - 1) begin
            rf[writeReg] = writeVal;
            wrote = 1;
         end
         if (resetAt >= 0 && accepted == resetAt) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check32("reset valid", 32'(outValid), 32'd0);
            check32("reset busy", 32'(busy), 32'd0);
            check32("reset data", outData, 32'd0);
            check32("reset tag", 32'(outTag), 32'd0);
            finished = 1;
         end else begin
            @(negedge clk);
            if (prevStall) begin
               check32("stall valid", 32'(outValid), 32'd1);
               check32("stall data", outData, prevData);
               check32("stall tag", 32'(outTag), 32'(prevTag));
            end
            // Disturb the register that will be loaded next while the bus is stalled.
            if (mode == 1 && outValid && !outReady && accepted + 1 <= 31)
               rf[accepted + 1] = rf[accepted + 1] + 32'h0011_1111;
            prevStall = outValid && !outReady;
            prevData  = outData;
            prevTag   = outTag;
            if (outValid && outReady) begin
               gotTag.push_back(outTag);
               gotData.push_back(outData);
               if (firstBeatCycle < 0) firstBeatCycle = cycle;
               lastBeatCycle = cycle;
               accepted++;
            end
            if (done) begin
               doneCycle = cycle;
               check32("done busy", 32'(busy), 32'd0);
               check32("done valid", 32'(outValid), 32'd0);
               finished = 1;
            end
            tick();
            cycle++;
         end
      end
      dumpReq = 1'b0;
      if (!finished) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout: got no done after %0d cycles, required done", cycle);
      end
   endtask

   task automatic checkOutput(input logic [31:0] pc, input int expDone);
      buildExpected(pc);
      check32("beat count", 32'(gotTag.size()), 32'(expTag.size()));
      for (int i = 0; i < expTag.size() && i < gotTag.size(); i++) begin
         check32($sformatf("beat%0d tag", i), 32'(gotTag[i]), 32'(expTag[i]));
         check32($sformatf("beat%0d data", i), gotData[i], expData[i]);
      end
      if (expDone > 0) begin
         check32("done cycle", 32'(doneCycle), 32'(expDone));
         check32("first beat cycle", 32'(firstBeatCycle), 32'd1);
         check32("last beat cycle", 32'(lastBeatCycle), 32'd33);
      end
   endtask

   task automatic idle(input int n);
      outReady = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int          doneBefore;
      logic [31:0] pcR;
      errors = 0; checks = 0; doneTotal = 0;
      reset = 1'b1; dumpReq = 1'b0; pcIn = '0; outReady = 1'b0;
      fillRf(32'h100, 0);
      vecs[0] = '{pc: 32'h0000_0040, rfBase: 32'h100,       mode: 0, reqA: -1, reqB: -1, expDone: 34};
      vecs[1] = '{pc: 32'h0000_0040, rfBase: 32'h100,       mode: 1, reqA: -1, reqB: -1, expDone: -1};
      vecs[2] = '{pc: 32'h1234_5678, rfBase: 32'hCAFE_0000, mode: 0, reqA: 5,  reqB: 20, expDone: 34};
      vecs[3] = '{pc: 32'hA5A5_0000, rfBase: 32'h0BAD_F000, mode: 1, reqA: 5,  reqB: 20, expDone: -1};
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b0;
      tick();

      $display("[TB] reset state");
      check32("rst valid", 32'(outValid), 32'd0);
      check32("rst data", outData, 32'd0);
      check32("rst tag", 32'(outTag), 32'd0);
      check32("rst raddr", 32'(rfRaddr), 32'd0);
      check32("rst busy", 32'(busy), 32'd0);
      check32("rst done", 32'(done), 32'd0);

      $display("[TB] table scenarios");
      for (int v = 0; v < 4; v++) begin
         fillRf(vecs[v].rfBase, 0);
         doneBefore = doneTotal;
         applyStimulus(vecs[v].pc, vecs[v].mode, vecs[v].reqA, vecs[v].reqB, -1, 0, 32'h0);
         checkOutput(vecs[v].pc, vecs[v].expDone);
         idle(4);
         check32($sformatf("vec%0d done pulses", v), 32'(doneTotal - doneBefore), 32'd1);
      end

      $display("[TB] reset mid-dump");
      fillRf(32'h100, 0);
      doneBefore = doneTotal;
      applyStimulus(32'h0000_0040, 0, -1, -1, 10, 0, 32'h0);
      buildExpected(32'h0000_0040);
      check32("partial beats", 32'(gotTag.size()), 32'd10);
      for (int i = 0; i < 10 && i < gotTag.size(); i++)
         check32($sformatf("partial%0d data", i), gotData[i], expData[i]);
      idle(6);
      check32("no done after reset", 32'(doneTotal - doneBefore), 32'd0);
      applyStimulus(32'h0000_0080, 0, -1, -1, -1, 0, 32'h0);
      checkOutput(32'h0000_0080, 34);
      idle(2);

      $display("[TB] late write to x5");
      fillRf(32'h100, 0);
      applyStimulus(32'h0000_0040, 0, -1, -1, -1, 5, 32'hDEAD_BEEF);
      checkOutput(32'h0000_0040, 34);
      if (gotData.size() > 5) check32("x5 word", gotData[5], 32'hDEAD_BEEF);
      idle(2);

      $display("[TB] back-to-back dumps");
      fillRf(32'h200, 0);
      doneBefore = doneTotal;
      applyStimulus(32'h0000_1000, 0, -1, -1, -1, 0, 32'h0);
      checkOutput(32'h0000_1000, 34);
      applyStimulus(32'h0000_2000, 0, -1, -1, -1, 0, 32'h0);
      checkOutput(32'h0000_2000, 34);
      idle(3);
      check32("b2b done pulses", 32'(doneTotal - doneBefore), 32'd2);

      $display("[TB] randomized dumps");
      for (int r = 0; r < 4; r++) begin
         fillRf(32'h0, 1);
         pcR = $urandom;
         doneBefore = doneTotal;
         applyStimulus(pcR, 2, -1, -1, -1, 0, 32'h0);
         checkOutput(pcR, -1);
         idle(3);
         check32($sformatf("rand%0d done pulses", r), 32'(doneTotal - doneBefore), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
